mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its MEM-stage data port.
- Serialises accesses: data first, then fetch.
- Returns registered read data to each requester.
- Drives a stall to the hazard unit, so the datapath freezes until every access requested in the current pipeline cycle has completed.
- Includes a watchdog that stops a missing memory ack from hanging the core.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : pipeline-side and memory-side signals of the arbiter
// Rev 1.0
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_re;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          stall_pipe;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          timeout_err;

   // Arbiter side.
   modport master (
      input  if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_rdata, d_rdata, stall_pipe, mem_req, mem_we, mem_addr, mem_wdata,
             timeout_err
   );

   // Pipeline plus memory side.
   modport slave (
      output if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_rdata, d_rdata, stall_pipe, mem_req, mem_we, mem_addr, mem_wdata,
             timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one variable-latency memory between fetch and data
// Rev 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int            AW       = 32,
   parameter int            DW       = 32,
   parameter int            TIMEOUT  = 64,
   parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic               clk,
   input  logic               reset_n,
   mem_port_arbiter_if.master bus
);
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_BUSY = 2'd1,
      I_BUSY = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          d_done_q, d_done_d;
   logic          i_done_q, i_done_d;
   logic          timeout_err_q, timeout_err_d;
   logic [WDW-1:0] wd_q, wd_d;

   logic d_acc, d_pend, i_pend, stall, expired, finish;

   assign d_acc   = bus.d_re | bus.d_we;
   assign d_pend  = d_acc & ~d_done_q;
   assign i_pend  = bus.if_req & ~i_done_q;
   assign stall   = d_pend | i_pend;
   assign expired = (wd_q == WDW'(TIMEOUT - 1));
   // A real ack in the last watchdog cycle takes precedence over the abort.
   assign finish  = bus.mem_ack | expired;

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_rdata_d    = if_rdata_q;
      d_rdata_d     = d_rdata_q;
      d_done_d      = d_done_q;
      i_done_d      = i_done_q;
      timeout_err_d = timeout_err_q;
      wd_d          = wd_q;

      if (!stall) begin
         d_done_d = 1'b0;
         i_done_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            wd_d = '0;
            if (d_pend) begin
               state_d     = D_BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
            end else if (i_pend) begin
               state_d    = I_BUSY;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.if_addr;
            end
         end

         D_BUSY: begin
            if (finish) begin
               wd_d     = '0;
               d_done_d = 1'b1;
               if (!bus.mem_ack) timeout_err_d = 1'b1;
               if (!mem_we_q) d_rdata_d = bus.mem_ack ? bus.mem_rdata : ERR_DATA;
               if (i_pend) begin
                  state_d    = I_BUSY;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus.if_addr;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
                  mem_we_d  = 1'b0;
               end
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         I_BUSY: begin
            if (finish) begin
               wd_d       = '0;
               i_done_d   = 1'b1;
               if (!bus.mem_ack) timeout_err_d = 1'b1;
               if_rdata_d = bus.mem_ack ? bus.mem_rdata : ERR_DATA;
               state_d    = IDLE;
               mem_req_d  = 1'b0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            wd_d      = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_rdata_q    <= '0;
         d_rdata_q     <= '0;
         d_done_q      <= 1'b0;
         i_done_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         wd_q          <= '0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_rdata_q    <= if_rdata_d;
         d_rdata_q     <= d_rdata_d;
         d_done_q      <= d_done_d;
         i_done_q      <= i_done_d;
         timeout_err_q <= timeout_err_d;
         wd_q          <= wd_d;
      end
   end

   assign bus.stall_pipe  = stall;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.timeout_err = timeout_err_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scoreboard bench with a memory responder model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int          AW   = 32;
   localparam int          DW   = 32;
   localparam int          TMO  = 8;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
   typedef struct { logic [31:0] i_val; logic [31:0] d_val; logic terr; } res_t;

   int tests = 0;
   int fails = 0;
   txn_t txn_q[$];
   res_t res_q[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] phys    [logic [31:0]];
   logic [31:0] exp_if = '0, exp_d = '0;
   logic        exp_terr = 1'b0;
   int  resp_wait = -1;
   bit  resp_en = 1'b1, resp_drop = 1'b0, force_ack = 1'b0;
   int  busy_sum = 0, stall_cnt = 0, last_busy = 0;

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h1357_9BDF);
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] a);
      return phys.exists(a) ? phys[a] : (a ^ 32'h1357_9BDF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      phys[a]    = v;
      ref_mem[a] = v;
   endtask

   // Memory model: returns an ack after a chosen number of wait cycles.
   initial begin : responder
      bit          in_txn;
      int          wl;
      logic [31:0] cap_addr, cap_wd;
      logic        cap_we;
      txn_t        t;
      in_txn = 1'b0;
      wl = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!resp_en) begin
            in_txn = 1'b0;
            bus.mem_ack = force_ack;
         end else if (!reset_n) begin
            in_txn = 1'b0;
            bus.mem_ack = 1'b0;
         end else begin
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
               busy_sum++;
               if (!resp_drop) begin
                  if (!in_txn) begin
                     in_txn   = 1'b1;
                     cap_addr = bus.mem_addr;
                     cap_we   = bus.mem_we;
                     cap_wd   = bus.mem_wdata;
                     wl       = (resp_wait < 0) ? int'($urandom_range(0, 3)) : resp_wait;
                  end else begin
                     chk("mem_addr_stable", bus.mem_addr, cap_addr);
                     chk("mem_we_stable", 32'(bus.mem_we), 32'(cap_we));
                  end
                  if (wl == 0) begin
                     in_txn = 1'b0;
                     bus.mem_ack = 1'b1;
                     if (txn_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_mem_req: addr %h issued, expected no access", bus.mem_addr);
                     end else begin
                        t = txn_q.pop_front();
                        chk("mem_we", 32'(bus.mem_we), 32'(t.we));
                        chk("mem_addr", bus.mem_addr, t.addr);
                        if (t.we) chk("mem_wdata", bus.mem_wdata, t.wdata);
                     end
                     if (bus.mem_we) phys[bus.mem_addr] = bus.mem_wdata;
                     else            bus.mem_rdata = phys_rd(bus.mem_addr);
                  end else begin
                     wl--;
                  end
               end
            end
         end
      end
   end

   // Checks results each time the pipeline is allowed to advance.
   initial begin : monitor
      res_t r;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (bus.stall_pipe) begin
               stall_cnt++;
            end else if (res_q.size() > 0) begin
               r = res_q.pop_front();
               chk("if_rdata", bus.if_rdata, r.i_val);
               chk("d_rdata", bus.d_rdata, r.d_val);
               chk("timeout_err", 32'(bus.timeout_err), 32'(r.terr));
               chk("stall_cycles", 32'(stall_cnt), 32'(busy_sum + 1));
               chk("txn_left", 32'(txn_q.size()), 32'd0);
               last_busy = busy_sum;
               busy_sum  = 0;
               stall_cnt = 0;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the pipeline advanced.
   task automatic do_op(input bit fe, input bit re, input bit we,
                        input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd);
      res_t r;
      txn_t t;
      int   n;
      bus.if_req  = fe;
      bus.if_addr = fa;
      bus.d_re    = re;
      bus.d_we    = we;
      bus.d_addr  = da;
      bus.d_wdata = wd;
      if (!(fe | re | we)) begin
         @(posedge clk);
         #1;
         return;
      end
      if (re | we) begin
         if (resp_drop) begin
            if (!we) exp_d = ERRD;
            exp_terr = 1'b1;
         end else begin
            t.we = we; t.addr = da; t.wdata = wd;
            txn_q.push_back(t);
            if (we) ref_mem[da] = wd;
            else    exp_d = ref_rd(da);
         end
      end
      if (fe) begin
         if (resp_drop) begin
            exp_if   = ERRD;
            exp_terr = 1'b1;
         end else begin
            t.we = 1'b0; t.addr = fa; t.wdata = '0;
            txn_q.push_back(t);
            exp_if = ref_rd(fa);
         end
      end
      r.i_val = exp_if; r.d_val = exp_d; r.terr = exp_terr;
      res_q.push_back(r);
      n = 0;
      while (res_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (res_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL op_timeout: stall_pipe %0b after 300 cycles, expected release", bus.stall_pipe);
         res_q.delete();
         txn_q.delete();
         busy_sum = 0;
         stall_cnt = 0;
      end
      #1;
   endtask

   task automatic rand_ops(input int cnt);
      bit fe, re, we;
      for (int i = 0; i < cnt; i++) begin
         fe = ($urandom_range(0, 3) != 0);
         re = ($urandom_range(0, 1) == 1);
         we = ($urandom_range(0, 2) == 0);
         do_op(fe, re, we, 32'($urandom_range(0, 15)) << 2,
               32'($urandom_range(0, 15)) << 2, $urandom);
      end
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "global timeout");
   end

   initial begin : driver
      bus.if_req = 0; bus.if_addr = '0; bus.d_re = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
      chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
      chk("rst_stall", 32'(bus.stall_pipe), 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Fetch only, load+fetch, store with both enables and a long ack delay.
      preload(32'h10, 32'h8C010004);
      preload(32'h100, 32'h55);
      preload(32'h14, 32'hAC020008);
      resp_wait = 0;
      do_op(1, 0, 0, 32'h10, 32'h0, 32'h0);
      do_op(1, 1, 0, 32'h14, 32'h100, 32'h0);
      resp_wait = 5;
      do_op(0, 1, 1, 32'h0, 32'h200, 32'hCAFEF00D);
      resp_wait = -1;
      rand_ops(150);

      // Missing ack on a load: watchdog aborts after TMO busy cycles.
      resp_drop = 1'b1;
      do_op(0, 1, 0, 32'h0, 32'h40, 32'h0);
      chk("timeout_busy_cycles", 32'(last_busy), 32'(TMO));
      resp_drop = 1'b0;
      rand_ops(40);

      // Reset in the middle of a data access, then a stray ack.
      resp_wait = 6;
      bus.if_req = 0; bus.d_re = 1; bus.d_we = 0; bus.d_addr = 32'h100;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_mem_req", 32'(bus.mem_req), 32'd1);
      reset_n = 1'b0;
      bus.d_re = 0;
      res_q.delete(); txn_q.delete();
      exp_if = '0; exp_d = '0; exp_terr = 1'b0;
      busy_sum = 0; stall_cnt = 0;
      #1;
      chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
      chk("reset_d_rdata", bus.d_rdata, 32'd0);
      chk("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
      chk("reset_mem_addr", bus.mem_addr, 32'd0);
      resp_en = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
      chk("late_ack_d_rdata", bus.d_rdata, 32'd0);
      chk("late_ack_if_rdata", bus.if_rdata, 32'd0);
      chk("late_ack_stall", 32'(bus.stall_pipe), 32'd0);
      resp_en = 1'b1;
      busy_sum = 0; stall_cnt = 0;
      @(posedge clk);
      #1;

      // Three back-to-back fetches with zero-wait acks.
      resp_wait = 0;
      do_op(1, 0, 0, 32'h20, 32'h0, 32'h0);
      do_op(1, 0, 0, 32'h24, 32'h0, 32'h0);
      do_op(1, 0, 0, 32'h28, 32'h0, 32'h0);
      resp_wait = -1;
      rand_ops(60);

      do_op(0, 0, 0, 32'h0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
